// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int ITER_LAST = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    function automatic logic busy(input state_t s);
        return (s == ST_MUL) || (s == ST_DIV);
    endfunction

endpackage

// File: rtl/multdiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface multdiv_if #(parameter int WIDTH = 32);

    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );

endinterface

// File: rtl/multdiv_datapath.sv
// Magnitude datapath: shift-add multiply / restoring divide on a 2*WIDTH accumulator,
// plus sign correction and overflow / divide-by-zero detection on the final value.
module multdiv_datapath
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  op_t              op,
    input  logic             neg,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] result,
    output logic             exception
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     prod_top;

    // Multiply keeps the multiplier in the low half and shifts right;
    // divide keeps the dividend in the low half and shifts quotient bits in from the right.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted  = {acc[2*WIDTH-2:0], 1'b0};
        trial    = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, opnd};
        if (op == OP_MUL) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else if (trial[WIDTH]) begin
            acc_next = shifted;
        end else begin
            acc_next = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            opnd <= (op == OP_MUL) ? a_mag : b_mag;
            acc  <= {{WIDTH{1'b0}}, ((op == OP_MUL) ? b_mag : a_mag)};
        end else if (step) begin
            acc <= acc_next;
        end
    end

    always_comb begin
        prod     = neg ? -acc : acc;
        quo      = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        prod_top = prod[2*WIDTH-1:WIDTH-1];
        result    = '0;
        exception = 1'b0;
        if (op == OP_MUL) begin
            result    = prod[WIDTH-1:0];
            exception = !((&prod_top) || !(|prod_top));
        end else if (opnd == '0) begin
            result    = '0;
            exception = 1'b1;
        end else begin
            // A positive quotient with the top bit set only arises from INT_MIN / -1.
            result    = quo;
            exception = !neg && acc[WIDTH-1];
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide responder: request latching, iteration counter,
// sequencing FSM and registered result/exception/ready outputs.
//   state   | meaning
//   ST_IDLE | waiting for ctrl_MULT / ctrl_DIV
//   ST_MUL  | shift-add iterations, then final result capture
//   ST_DIV  | restoring-divide iterations, then final result capture
//   ST_DONE | data_resultRDY high for this single cycle
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = ITER_LAST
) (
    input  logic     clock,
    input  logic     reset,
    multdiv_if.slave bus
);

    localparam int CNT_W = $clog2(ITER + 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    op_t              op_q;
    logic             neg_q;

    logic             start;
    logic             last;
    logic             step;
    logic             neg_new;
    op_t              op_new;
    op_t              op_sel;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] dp_result;
    logic             dp_exception;

    assign start   = bus.ctrl_MULT | bus.ctrl_DIV;
    assign op_new  = bus.ctrl_MULT ? OP_MUL : OP_DIV;
    assign op_sel  = start ? op_new : op_q;
    assign neg_new = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
    assign a_mag   = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign b_mag   = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
    assign last    = (count == CNT_W'(ITER));
    assign step    = !start && busy(state) && !last;

    multdiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock     (clock),
        .reset     (reset),
        .load      (start),
        .step      (step),
        .op        (op_sel),
        .neg       (start ? neg_new : neg_q),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .result    (dp_result),
        .exception (dp_exception)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            count              <= '0;
            op_q               <= OP_MUL;
            neg_q              <= 1'b0;
            bus.data_result    <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
        end else begin
            bus.data_resultRDY <= 1'b0;
            // A new request always wins, even over an operation about to finish.
            if (start) begin
                state <= bus.ctrl_MULT ? ST_MUL : ST_DIV;
                op_q  <= op_new;
                neg_q <= neg_new;
                count <= '0;
            end else begin
                case (state)
                    ST_MUL, ST_DIV: begin
                        if (last) begin
                            state              <= ST_DONE;
                            bus.data_result    <= dp_result;
                            bus.data_exception <= dp_exception;
                            bus.data_resultRDY <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases, restart/reset scenarios and
// randomized operations against an integer-arithmetic reference model.
module tb_multdiv_unit;
    import multdiv_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   n_asserts = 0;
    int   n_fail    = 0;

    multdiv_if #(.WIDTH(32)) bus ();

    multdiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint sa;
        longint sb;
        longint p;
        logic [31:0] lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mul) begin
            p  = sa * sb;
            lo = p[31:0];
            r  = lo;
            e  = (p != longint'($signed(lo)));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
            r = INT_MIN;
            e = 1'b1;
        end else begin
            p = sa / sb;
            r = p[31:0];
            e = 1'b0;
        end
    endfunction

    task automatic run_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_e, input string tag);
        int lat;
        int pulses;
        logic [31:0] r;
        logic e;
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = mul;
        bus.ctrl_DIV      = div;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        check({tag, " rdy_after_accept"}, 32'(bus.data_resultRDY), 32'd0);
        lat    = -1;
        pulses = 0;
        r      = 'x;
        e      = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    r   = bus.data_result;
                    e   = bus.data_exception;
                end
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd33);
        check({tag, " rdy_pulses"}, 32'(pulses), 32'd1);
        check({tag, " result"}, r, exp_r);
        check({tag, " exception"}, 32'(e), 32'(exp_e));
        check({tag, " result_hold"}, bus.data_result, exp_r);
    endtask

    task automatic run_rand(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic e;
        model(is_mul, a, b, r, e);
        run_op(is_mul, !is_mul, a, b, r, e, is_mul ? "rand_mul" : "rand_div");
    endtask

    initial begin
        logic [31:0] specials [4];
        logic [31:0] ra;
        logic [31:0] rb;
        int lat;
        int pulses;
        int pk [2];
        logic [31:0] pr [2];
        logic [31:0] res_seen;
        specials[0] = INT_MIN;
        specials[1] = 32'd0;
        specials[2] = 32'd1;
        specials[3] = 32'hFFFF_FFFF;

        reset             = 1'b1;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        #12;
        check("reset result", bus.data_result, 32'd0);
        check("reset exception", 32'(bus.data_exception), 32'd0);
        check("reset rdy", 32'(bus.data_resultRDY), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_m3");
        run_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, "mul_ovf");
        run_op(1, 0, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0, "mul_max");
        run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
        run_op(0, 1, 32'd100, 32'd7, 32'd14, 1'b0, "div_100_7");
        run_op(0, 1, 32'd5, 32'd0, 32'd0, 1'b1, "div_by_zero");
        run_op(0, 1, INT_MIN, 32'hFFFF_FFFF, INT_MIN, 1'b1, "div_ovf");
        run_op(1, 1, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFD6, 1'b0, "both_ctrl_mul_wins");

        // Restart mid-multiply with a divide accepted 10 edges later.
        @(negedge clock);
        bus.data_operandA = 32'd3;
        bus.data_operandB = 32'd4;
        bus.ctrl_MULT     = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        lat = -1;
        pulses = 0;
        res_seen = 'x;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    res_seen = bus.data_result;
                end
            end
            if (k == 9) begin
                bus.data_operandA = 32'd100;
                bus.data_operandB = 32'd7;
                bus.ctrl_DIV      = 1'b1;
            end
            if (k == 10) bus.ctrl_DIV = 1'b0;
        end
        check("restart latency", 32'(lat), 32'd43);
        check("restart rdy_pulses", 32'(pulses), 32'd1);
        check("restart result", res_seen, 32'd14);

        // New request landing on the DONE cycle: both operations report.
        @(negedge clock);
        bus.data_operandA = 32'd6;
        bus.data_operandB = 32'd7;
        bus.ctrl_MULT     = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        pulses = 0;
        pk[0] = -1; pk[1] = -1;
        pr[0] = 'x; pr[1] = 'x;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY) begin
                if (pulses < 2) begin
                    pk[pulses] = k;
                    pr[pulses] = bus.data_result;
                end
                pulses++;
            end
            if (k == 33) begin
                bus.data_operandA = 32'hFFFF_FFD6;
                bus.data_operandB = 32'd5;
                bus.ctrl_DIV      = 1'b1;
            end
            if (k == 34) bus.ctrl_DIV = 1'b0;
        end
        check("done_overlap pulses", 32'(pulses), 32'd2);
        check("done_overlap first_at", 32'(pk[0]), 32'd33);
        check("done_overlap first_result", pr[0], 32'd42);
        check("done_overlap second_at", 32'(pk[1]), 32'd67);
        check("done_overlap second_result", pr[1], 32'hFFFF_FFF8);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clock);
        bus.data_operandA = 32'd3;
        bus.data_operandB = 32'd5;
        bus.ctrl_MULT     = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        for (int k = 1; k <= 15; k++) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_reset result", bus.data_result, 32'd0);
        check("async_reset exception", 32'(bus.data_exception), 32'd0);
        check("async_reset rdy", 32'(bus.data_resultRDY), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY) pulses++;
        end
        check("after_reset no_rdy", 32'(pulses), 32'd0);
        run_op(1, 0, 32'd2, 32'd2, 32'd4, 1'b0, "mul_2x2_after_reset");

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = 32'($signed($urandom_range(0, 200)) - 100);
                         rb = 32'($signed($urandom_range(0, 200)) - 100); end
                2: begin ra = $urandom; rb = 32'($signed($urandom_range(0, 2000)) - 1000); end
                default: begin ra = specials[$urandom_range(0, 3)]; rb = specials[$urandom_range(0, 3)]; end
            endcase
            run_rand(bit'($urandom_range(0, 1)), ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
